multi_cycle_control_unit: RTL and testbench

//  Multi-cycle RV32I control FSM; successor to the single-cycle decoder. Sequences each

---
 rtl/multi_cycle_control_unit_if.sv | 36 +++
 rtl/multi_cycle_control_unit.sv | 205 ++++++++++++++++++++
 tb/tb_multi_cycle_control_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_control_unit_if.sv
// Control bundle between the multi-cycle control FSM and the shared datapath.
// master: the control unit (consumes IR/status, drives enables and selects).
// slave : the datapath side (drives IR/status, consumes enables and selects).
interface multi_cycle_control_unit_if #(
    parameter int unsigned ALU_CTRL_W = 4,
    parameter int unsigned RFWD_SEL_W = 3
);
    // datapath -> control
    logic [31:0]            instrCode;
    logic                   btaken;
    logic                   busReady;

    // control -> datapath
    logic                   pcEn;
    logic                   irWe;
    logic                   regFileWe;
    logic [ALU_CTRL_W-1:0]  aluControl;
    logic                   aluSrcMuxSel;
    logic                   dataWe;
    logic                   dataReq;
    logic [RFWD_SEL_W-1:0]  RFWDSrcMuxSel;
    logic [1:0]             pcSrcMuxSel;
    logic                   illegal;

    modport master (
        input  instrCode, btaken, busReady,
        output pcEn, irWe, regFileWe, aluControl, aluSrcMuxSel,
               dataWe, dataReq, RFWDSrcMuxSel, pcSrcMuxSel, illegal
    );

    modport slave (
        output instrCode, btaken, busReady,
        input  pcEn, irWe, regFileWe, aluControl, aluSrcMuxSel,
               dataWe, dataReq, RFWDSrcMuxSel, pcSrcMuxSel, illegal
    );
endinterface

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32I control FSM. Walks each instruction through
// FETCH/DECODE/EXECUTE[/MEM[/WB]], decodes datapath controls from the state
// and the held IR, stalls in MEM on busReady and parks in TRAP on an
// unsupported opcode until reset.
module multi_cycle_control_unit #(
    parameter int unsigned ALU_CTRL_W    = 4,
    parameter int unsigned RFWD_SEL_W    = 3,
    parameter bit          SUPPORT_UPPER = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    multi_cycle_control_unit_if.master bus
);

    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] OPC_R     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_I     = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_B     = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_S     = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_L     = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_LUI   = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL   = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR  = 7'b1100111;

    localparam logic [RFWD_SEL_W-1:0] RFWD_ALU   = RFWD_SEL_W'(0);
    localparam logic [RFWD_SEL_W-1:0] RFWD_MEM   = RFWD_SEL_W'(1);
    localparam logic [RFWD_SEL_W-1:0] RFWD_IMM   = RFWD_SEL_W'(2);
    localparam logic [RFWD_SEL_W-1:0] RFWD_PCIMM = RFWD_SEL_W'(3);
    localparam logic [RFWD_SEL_W-1:0] RFWD_PC4   = RFWD_SEL_W'(4);

    localparam logic [1:0] PCSRC_PC4   = 2'd0;
    localparam logic [1:0] PCSRC_PCIMM = 2'd1;
    localparam logic [1:0] PCSRC_RS1   = 2'd2;

    localparam logic [2:0] F3_SR = 3'b101;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WB,
        TRAP
    } state_t;

    typedef enum logic [3:0] {
        OP_R,
        OP_I,
        OP_B,
        OP_S,
        OP_L,
        OP_LUI,
        OP_AUIPC,
        OP_JAL,
        OP_JALR,
        OP_ILL
    } op_class_t;

    // Map an opcode to its instruction class; upper/jump opcodes are only
    // legal when the datapath supports them.
    function automatic op_class_t decode_op(input logic [OPC_W-1:0] opc);
        op_class_t cls;
        cls = OP_ILL;
        case (opc)
            OPC_R:     cls = OP_R;
            OPC_I:     cls = OP_I;
            OPC_B:     cls = OP_B;
            OPC_S:     cls = OP_S;
            OPC_L:     cls = OP_L;
            OPC_LUI:   cls = SUPPORT_UPPER ? OP_LUI   : OP_ILL;
            OPC_AUIPC: cls = SUPPORT_UPPER ? OP_AUIPC : OP_ILL;
            OPC_JAL:   cls = SUPPORT_UPPER ? OP_JAL   : OP_ILL;
            OPC_JALR:  cls = SUPPORT_UPPER ? OP_JALR  : OP_ILL;
            default:   cls = OP_ILL;
        endcase
        return cls;
    endfunction

    state_t            state;
    op_class_t         op;
    logic [OPC_W-1:0]  opcode;
    logic [2:0]        funct3;
    logic              funct7_5;
    logic              is_mem_op;

    // IR fields consumed by the controller
    assign opcode    = bus.instrCode[6:0];
    assign funct3    = bus.instrCode[14:12];
    assign funct7_5  = bus.instrCode[30];
    assign op        = decode_op(opcode);
    assign is_mem_op = (op == OP_S) || (op == OP_L);

    // State sequencing; reset overrides every transition including MEM stall and TRAP
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   state <= DECODE;
                DECODE:  state <= (op == OP_ILL) ? TRAP : EXECUTE;
                EXECUTE: state <= is_mem_op ? MEM : FETCH;
                MEM: begin
                    if (bus.busReady) begin
                        state <= (op == OP_L) ? WB : FETCH;
                    end
                end
                WB:      state <= FETCH;
                TRAP:    state <= TRAP;
                default: state <= FETCH;
            endcase
        end
    end

    // Datapath controls decoded from the current state and the held IR
    always_comb begin
        bus.pcEn          = 1'b0;
        bus.irWe          = 1'b0;
        bus.regFileWe     = 1'b0;
        bus.aluControl    = '0;
        bus.aluSrcMuxSel  = 1'b0;
        bus.dataWe        = 1'b0;
        bus.dataReq       = 1'b0;
        bus.RFWDSrcMuxSel = RFWD_ALU;
        bus.pcSrcMuxSel   = PCSRC_PC4;
        bus.illegal       = 1'b0;

        case (state)
            FETCH: begin
                bus.irWe = 1'b1;
            end
            DECODE: begin
            end
            EXECUTE: begin
                case (op)
                    OP_R: begin
                        bus.aluControl = ALU_CTRL_W'({funct7_5, funct3});
                        bus.regFileWe  = 1'b1;
                        bus.pcEn       = 1'b1;
                    end
                    OP_I: begin
                        // funct7[5] only selects SRAI vs SRLI; elsewhere it is immediate data
                        bus.aluSrcMuxSel = 1'b1;
                        bus.aluControl   = (funct3 == F3_SR) ? ALU_CTRL_W'({funct7_5, funct3})
                                                             : ALU_CTRL_W'({1'b0, funct3});
                        bus.regFileWe    = 1'b1;
                        bus.pcEn         = 1'b1;
                    end
                    OP_B: begin
                        bus.aluControl  = ALU_CTRL_W'({1'b0, funct3});
                        bus.pcEn        = 1'b1;
                        bus.pcSrcMuxSel = bus.btaken ? PCSRC_PCIMM : PCSRC_PC4;
                    end
                    OP_LUI: begin
                        bus.RFWDSrcMuxSel = RFWD_IMM;
                        bus.regFileWe     = 1'b1;
                        bus.pcEn          = 1'b1;
                    end
                    OP_AUIPC: begin
                        bus.RFWDSrcMuxSel = RFWD_PCIMM;
                        bus.regFileWe     = 1'b1;
                        bus.pcEn          = 1'b1;
                    end
                    OP_JAL: begin
                        bus.RFWDSrcMuxSel = RFWD_PC4;
                        bus.pcSrcMuxSel   = PCSRC_PCIMM;
                        bus.regFileWe     = 1'b1;
                        bus.pcEn          = 1'b1;
                    end
                    OP_JALR: begin
                        bus.RFWDSrcMuxSel = RFWD_PC4;
                        bus.pcSrcMuxSel   = PCSRC_RS1;
                        bus.regFileWe     = 1'b1;
                        bus.pcEn          = 1'b1;
                    end
                    OP_S, OP_L: begin
                        // effective address = rs1 + imm
                        bus.aluSrcMuxSel = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            MEM: begin
                // held steady while the bus stalls; a store retires on the ready cycle
                bus.aluSrcMuxSel = 1'b1;
                bus.dataReq      = 1'b1;
                bus.dataWe       = (op == OP_S);
                bus.pcEn         = (op == OP_S) && bus.busReady;
            end
            WB: begin
                bus.RFWDSrcMuxSel = RFWD_MEM;
                bus.regFileWe     = 1'b1;
                bus.pcEn          = 1'b1;
            end
            TRAP: begin
                bus.illegal = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Bench for multi_cycle_control_unit: per-instruction expected control
// sequences are queued by the stimulus and checked cycle by cycle by a monitor.
module tb_multi_cycle_control_unit;

    typedef struct packed {
        logic       pcEn;
        logic       irWe;
        logic       regFileWe;
        logic [3:0] alu;
        logic       aluSrc;
        logic       dataWe;
        logic       dataReq;
        logic [2:0] rfwd;
        logic [1:0] pcSrc;
        logic       illegal;
    } ctrl_t;

    typedef enum {C_R, C_I, C_B, C_S, C_L, C_LUI, C_AUIPC, C_JAL, C_JALR, C_ILL} cls_e;

    logic clk;
    logic rst0;
    logic rst1;

    multi_cycle_control_unit_if #(.ALU_CTRL_W(4), .RFWD_SEL_W(3)) if0 ();
    multi_cycle_control_unit_if #(.ALU_CTRL_W(4), .RFWD_SEL_W(3)) if1 ();

    multi_cycle_control_unit #(.ALU_CTRL_W(4), .RFWD_SEL_W(3), .SUPPORT_UPPER(1'b1)) u_dut (
        .clk   (clk),
        .reset (rst0),
        .bus   (if0.master)
    );

    multi_cycle_control_unit #(.ALU_CTRL_W(4), .RFWD_SEL_W(3), .SUPPORT_UPPER(1'b0)) u_dut_nu (
        .clk   (clk),
        .reset (rst1),
        .bus   (if1.master)
    );

    ctrl_t q0[$];
    ctrl_t q1[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    logic [6:0] opc_tab [0:9] = '{7'h33, 7'h13, 7'h63, 7'h23, 7'h03,
                                   7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic cls_e classify(input logic [31:0] ins, input bit upper);
        case (ins[6:0])
            7'h33:   return C_R;
            7'h13:   return C_I;
            7'h63:   return C_B;
            7'h23:   return C_S;
            7'h03:   return C_L;
            7'h37:   return upper ? C_LUI   : C_ILL;
            7'h17:   return upper ? C_AUIPC : C_ILL;
            7'h6F:   return upper ? C_JAL   : C_ILL;
            7'h67:   return upper ? C_JALR  : C_ILL;
            default: return C_ILL;
        endcase
    endfunction

    function automatic ctrl_t w_fetch();
        ctrl_t w = '0;
        w.irWe = 1'b1;
        return w;
    endfunction

    function automatic ctrl_t w_trap();
        ctrl_t w = '0;
        w.illegal = 1'b1;
        return w;
    endfunction

    function automatic ctrl_t w_mem(input bit is_store, input logic br);
        ctrl_t w = '0;
        w.aluSrc  = 1'b1;
        w.dataReq = 1'b1;
        w.dataWe  = is_store;
        w.pcEn    = is_store && br;
        return w;
    endfunction

    function automatic ctrl_t w_wb();
        ctrl_t w = '0;
        w.rfwd      = 3'd1;
        w.regFileWe = 1'b1;
        w.pcEn      = 1'b1;
        return w;
    endfunction

    // What the datapath must see in the execute step of an instruction
    function automatic ctrl_t w_exec(input logic [31:0] ins, input bit upper, input logic bt);
        ctrl_t      w  = '0;
        logic [2:0] f3 = ins[14:12];
        logic       f7 = ins[30];
        cls_e       c  = classify(ins, upper);
        bit         writes_rd = (c == C_R) || (c == C_I) || (c == C_LUI) ||
                                (c == C_AUIPC) || (c == C_JAL) || (c == C_JALR);
        bit         retires   = writes_rd || (c == C_B);
        w.regFileWe = writes_rd;
        w.pcEn      = retires;
        if (c == C_R) w.alu = {f7, f3};
        if (c == C_I) w.alu = (f3 == 3'd5) ? {f7, f3} : {1'b0, f3};
        if (c == C_B) w.alu = {1'b0, f3};
        w.aluSrc = (c == C_I) || (c == C_S) || (c == C_L);
        if (c == C_LUI)   w.rfwd = 3'd2;
        if (c == C_AUIPC) w.rfwd = 3'd3;
        if (c == C_JAL || c == C_JALR) w.rfwd = 3'd4;
        if (c == C_JAL)  w.pcSrc = 2'd1;
        if (c == C_JALR) w.pcSrc = 2'd2;
        if (c == C_B)    w.pcSrc = bt ? 2'd1 : 2'd0;
        return w;
    endfunction

    // ---------------- stimulus ----------------
    // One clock of stimulus for the selected DUT; the other DUT is held in reset
    task automatic emit(input int which, input logic [31:0] ins, input logic rst,
                        input logic br, input logic bt, input ctrl_t exp);
        @(posedge clk);
        #1;
        if (which == 0) begin
            rst0 = rst; rst1 = 1'b1;
            if0.instrCode = ins; if0.busReady = br; if0.btaken = bt;
            q0.push_back(exp);
        end else begin
            rst1 = rst; rst0 = 1'b1;
            if1.instrCode = ins; if1.busReady = br; if1.btaken = bt;
            q1.push_back(exp);
        end
    endtask

    task automatic tick(input int which, input logic [31:0] ins, input logic br,
                        input logic bt, input ctrl_t exp, input bit force_rst,
                        input int rst_at, inout int k, inout bit done);
        logic r;
        if (!done) begin
            r = force_rst || (k == rst_at);
            emit(which, ins, r, br, bt, exp);
            done = r;
            k++;
        end
    endtask

    // Drive one instruction and queue its expected per-cycle controls.
    // rst_at: cycle index within the instruction at which reset is pulsed (-1 none).
    task automatic run_instr(input int which, input logic [31:0] ins, input int nwait,
                             input int rst_at, input int bt_mode, input int trap_len);
        bit    upper = (which == 0);
        cls_e  c     = classify(ins, upper);
        int    k     = 0;
        bit    done  = 1'b0;
        logic  bt;
        logic  br;
        bt = (bt_mode == 2) ? 1'($urandom_range(0, 1)) : (bt_mode != 0);
        tick(which, ins, 1'($urandom_range(0, 1)), bt, w_fetch(), 1'b0, rst_at, k, done);
        tick(which, ins, 1'($urandom_range(0, 1)), bt, ctrl_t'('0), 1'b0, rst_at, k, done);
        if (c == C_ILL) begin
            for (int t = 0; t < trap_len; t++)
                tick(which, ins, 1'($urandom_range(0, 1)), bt, w_trap(), 1'b0, rst_at, k, done);
            tick(which, ins, 1'($urandom_range(0, 1)), bt, w_trap(), 1'b1, rst_at, k, done);
        end else begin
            tick(which, ins, 1'($urandom_range(0, 1)), bt, w_exec(ins, upper, bt), 1'b0, rst_at, k, done);
            if (c == C_S || c == C_L) begin
                for (int w = 0; w <= nwait; w++) begin
                    br = (w == nwait) && (k != rst_at);
                    tick(which, ins, br, bt, w_mem(c == C_S, br), 1'b0, rst_at, k, done);
                end
                if (c == C_L)
                    tick(which, ins, 1'($urandom_range(0, 1)), bt, w_wb(), 1'b0, rst_at, k, done);
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r   = $urandom();
        int          idx = $urandom_range(0, 10);
        logic [6:0]  opc;
        opc = (idx == 10) ? 7'($urandom()) : opc_tab[idx];
        return {r[31:7], opc};
    endfunction

    // ---------------- monitor ----------------
    // Compare every cycle for which an expectation is queued
    always @(negedge clk) begin
        ctrl_t e;
        ctrl_t g;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            g = {if0.pcEn, if0.irWe, if0.regFileWe, if0.aluControl, if0.aluSrcMuxSel,
                 if0.dataWe, if0.dataReq, if0.RFWDSrcMuxSel, if0.pcSrcMuxSel, if0.illegal};
            n_cmp++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL ctrl dut_upper t=%0t ir=%h got=%h expected=%h",
                         $time, if0.instrCode, g, e);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            g = {if1.pcEn, if1.irWe, if1.regFileWe, if1.aluControl, if1.aluSrcMuxSel,
                 if1.dataWe, if1.dataReq, if1.RFWDSrcMuxSel, if1.pcSrcMuxSel, if1.illegal};
            n_cmp++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL ctrl dut_noupper t=%0t ir=%h got=%h expected=%h",
                         $time, if1.instrCode, g, e);
            end
        end
    end

    // Bound on total run time
    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        if0.instrCode = '0; if0.busReady = 1'b0; if0.btaken = 1'b0;
        if1.instrCode = '0; if1.busReady = 1'b0; if1.btaken = 1'b0;
        repeat (2) @(posedge clk);
        // still in reset: state already forced to FETCH
        emit(0, 32'h0, 1'b1, 1'b0, 1'b0, w_fetch());

        run_instr(0, 32'h002081B3, 0, -1, 2, 0);     // add x3,x1,x2
        run_instr(0, 32'h0000A183, 2, -1, 2, 0);     // lw with 2 stall cycles
        run_instr(0, 32'h00208463, 0, -1, 1, 0);     // beq taken
        run_instr(0, 32'h00208463, 0, -1, 0, 0);     // beq not taken
        run_instr(0, 32'h4010D093, 0, -1, 2, 0);     // srai
        run_instr(0, 32'h40000093, 0, -1, 2, 0);     // addi, imm[10]=1
        run_instr(0, 32'h0000007F, 0, -1, 2, 10);    // illegal, trap 10 cycles
        run_instr(0, 32'h002081B3, 0, -1, 2, 0);
        run_instr(0, 32'h0020A023, 5, 5, 2, 0);      // sw, reset during MEM stall
        run_instr(0, 32'h0020A023, 1, -1, 2, 0);     // sw completing
        run_instr(0, 32'h123450B7, 0, -1, 2, 0);     // lui
        run_instr(0, 32'h00001097, 0, -1, 2, 0);     // auipc
        run_instr(0, 32'h008000EF, 0, -1, 2, 0);     // jal
        run_instr(0, 32'h000080E7, 0, -1, 2, 0);     // jalr

        for (int n = 0; n < 400; n++) begin
            int rst_at = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 6)) : -1;
            run_instr(0, rand_instr(), $urandom_range(0, 3), rst_at, 2, $urandom_range(0, 4));
        end

        run_instr(1, 32'h123450B7, 0, -1, 2, 3);     // lui traps without upper support
        run_instr(1, 32'h002081B3, 0, -1, 2, 0);
        run_instr(1, 32'h0000A183, 1, -1, 2, 0);
        run_instr(1, 32'h008000EF, 0, -1, 2, 2);     // jal traps too
        for (int n = 0; n < 60; n++) begin
            run_instr(1, rand_instr(), $urandom_range(0, 2), -1, 2, $urandom_range(0, 3));
        end

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain: queued expectations left q0=%0d q1=%0d required 0",
                     q0.size(), q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
